qcw_burst_ctrl: RTL and testbench
=================================

// Module: qcw_burst_ctrl
// PURPOSE
//  Sequences one QCW burst around the overcurrent detector: arms and clears the detector, ramps the
//  bridge power setpoint, aborts on OCD halt, captures the burst peak current, enforces cooldown.
//  Sits between the trigger/control logic and the bridge drive plus OCD monitor in the coil firmware.
// PARAMETERS
//  ARM_CYCLES      4       cycles between OCD clear and bridge enable (OCD filter settle), >=1
//  RAMP_CYCLES     2000    ramp duration in clk cycles, >=1
//  POWER_MAX       1023    final power_level value, 10-bit, >=1
//  COOLDOWN_CYCLES 100000  minimum dead time after any burst end, >=1
//  TRIP_LIMIT      3       consecutive OCD trips that cause lockout (fault-latch build only), 1..15
// PORTS
//  clk             in   1   system clock
//  rst             in   1   asynchronous reset, active high
//  trigger         in   1   burst request, level; rising edge starts a burst
//  abort           in   1   synchronous stop request, level
//  fault_clr       in   1   clears lockout (fault-latch build only)
//  ocd_halt        in   1   OCD overcurrent flag
//  ocd_current_max in   10  OCD running peak current magnitude
//  ocd_start       out  1   one-cycle pulse clearing OCD peak
//  ocd_enable      out  1   OCD enable, high ARM..RAMP
//  bridge_en       out  1   bridge gate drive enable
//  power_level     out  10  ramp setpoint to phase/power logic
//  busy            out  1   high in any state except IDLE
//  last_peak       out  10  peak current of the last completed burst
//  peak_valid      out  1   one-cycle pulse when last_peak updates
//  ocd_trip        out  1   sticky: last burst ended by OCD; cleared at next burst start
//  trip_count      out  4   consecutive-trip count, saturates at 15
//  locked          out  1   high in FAULT state
// BEHAVIOUR
//  - All outputs registered; reset clears every output to 0 and the FSM to IDLE asynchronously.
//  - Reset mid-burst drops bridge_en immediately; no peak capture.
//  - FSM: IDLE -> ARM -> RAMP -> COOLDOWN -> IDLE; FAULT reached from COOLDOWN only.
//  - IDLE: trigger rising edge (registered previous-trigger compare) -> ARM next cycle, with
//    ocd_start=1 for that first ARM cycle only; ocd_enable=1; ocd_trip cleared.
//  - ARM: ARM_CYCLES cycles, bridge_en=0, power_level=0; then RAMP.
//  - RAMP: bridge_en=1 for exactly RAMP_CYCLES cycles. Setpoint via Bresenham accumulator:
//    acc+=POWER_MAX each cycle; while acc>=RAMP_CYCLES, acc-=RAMP_CYCLES and power_level+=1;
//    power_level saturates at POWER_MAX and equals POWER_MAX on the last RAMP cycle. No divider.
//  - ocd_halt sampled high in ARM or RAMP: next cycle COOLDOWN, bridge_en=0, ocd_trip=1,
//    trip_count+1 (saturating). abort high in ARM/RAMP: COOLDOWN, no trip.
//  - Priority when simultaneous: ocd_halt > abort > ramp completion.
//  - Clean completion or abort resets trip_count to 0.
//  - COOLDOWN entry cycle: last_peak<=ocd_current_max, peak_valid=1 one cycle; ocd_enable=0,
//    power_level=0. Lasts COOLDOWN_CYCLES cycles, then IDLE.
//  - trigger edges outside IDLE are dropped (no queueing); trigger held high across COOLDOWN
//    does not retrigger -- a new rising edge is required.
// CONFIGURATION
//  QCW_FAULT_LATCH_EN defined: at COOLDOWN end, if trip_count>=TRIP_LIMIT go FAULT: locked=1,
//    triggers ignored; fault_clr high -> IDLE next cycle, trip_count=0, locked=0.
//  Undefined: FAULT unreachable, locked tied 0, fault_clr ignored; trip_count still counts.
// TESTING
//  - Clean burst, ARM=4,RAMP=8,POWER_MAX=1023: trigger edge -> ocd_start 1 cycle, bridge_en 8
//    cycles, power_level monotonic ending 1023, peak_valid with last_peak=ocd_current_max.
//  - ocd_halt at RAMP cycle 3 -> bridge_en low next cycle, ocd_trip=1, trip_count=1, COOLDOWN.
//  - halt+abort same cycle on final RAMP cycle -> treated as trip, trip_count increments.
//  - Triggers during RAMP and COOLDOWN, trigger held high -> no second burst until new edge.
//  - QCW_FAULT_LATCH_EN, TRIP_LIMIT=3: three tripped bursts -> locked=1, triggers ignored;
//    fault_clr -> IDLE, trip_count=0; without macro same stimulus -> locked stays 0.
//  - rst asserted mid-RAMP -> bridge_en, busy, power_level 0 without a clk edge; FSM IDLE.

Source files
------------

// File: rtl/qcw_burst_ctrl.sv
// ---------------------------------------------------------------------------
// qcw_burst_ctrl
//
// Sequences a single QCW burst around the overcurrent detector (OCD).
// Each burst runs these steps in order:
//   1. Clear and arm the OCD.
//   2. Wait for the OCD filter to settle.
//   3. Ramp the bridge power setpoint with a Bresenham accumulator.
//   4. Abort early on an OCD halt or an external abort.
//   5. Capture the burst peak current.
//   6. Enforce a cooldown dead time before the next burst is accepted.
//
// Build option:
//   QCW_FAULT_LATCH_EN  when defined, TRIP_LIMIT consecutive OCD-ended bursts
//                       latch the FAULT state until fault_clr. When undefined,
//                       FAULT is unreachable and locked stays 0.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   trigger           burst request (a rising edge starts a burst)
//   abort             synchronous stop request
//   fault_clr         leaves the FAULT state
//   ocd_halt          OCD overcurrent flag
//   ocd_current_max   OCD running peak current
//   ocd_start         one-cycle pulse clearing the OCD peak
//   ocd_enable        OCD enable during ARM and RAMP
//   bridge_en         bridge gate drive enable (RAMP only)
//   power_level       ramp setpoint
//   busy              high whenever the FSM is not IDLE
//   last_peak         peak current of the last burst
//   peak_valid        one-cycle pulse when last_peak updates
//   ocd_trip          last burst was ended by the OCD
//   trip_count        consecutive OCD-ended bursts (saturating)
//   locked            high in the FAULT state
// ---------------------------------------------------------------------------
module qcw_burst_ctrl #(
    parameter int ARM_CYCLES      = 4,
    parameter int RAMP_CYCLES     = 2000,
    parameter int POWER_MAX       = 1023,
    parameter int COOLDOWN_CYCLES = 100000,
    parameter int TRIP_LIMIT      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger,
    input  logic       abort,
    input  logic       fault_clr,
    input  logic       ocd_halt,
    input  logic [9:0] ocd_current_max,
    output logic       ocd_start,
    output logic       ocd_enable,
    output logic       bridge_en,
    output logic [9:0] power_level,
    output logic       busy,
    output logic [9:0] last_peak,
    output logic       peak_valid,
    output logic       ocd_trip,
    output logic [3:0] trip_count,
    output logic       locked
);

`ifdef QCW_FAULT_LATCH_EN
    localparam bit FAULT_LATCH = 1'b1;
`else
    localparam bit FAULT_LATCH = 1'b0;
`endif

    localparam int CNT_MAX0 = (ARM_CYCLES > RAMP_CYCLES) ? ARM_CYCLES : RAMP_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > COOLDOWN_CYCLES) ? CNT_MAX0 : COOLDOWN_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    // The per-cycle increment POWER_MAX/RAMP_CYCLES is split into an integer
    // part and a remainder at elaboration time. The accumulator then only
    // handles the remainder, so at most one extra step is needed per cycle
    // and no hardware divider is required.
    localparam int STEP_Q = POWER_MAX / RAMP_CYCLES;
    localparam int STEP_R = POWER_MAX % RAMP_CYCLES;
    localparam int ACC_W  = $clog2(2 * RAMP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RAMP,
        S_COOLDOWN,
        S_FAULT
    } state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [ACC_W-1:0]   acc, acc_d;
    logic               trig_prev;

    logic               trig_rise;
    logic               arm_last, ramp_last, cool_last, fault_entry;

    logic               ocd_start_d, ocd_enable_d, bridge_en_d, busy_d;
    logic               peak_valid_d, ocd_trip_d, locked_d;
    logic [9:0]         power_level_d, last_peak_d;
    logic [3:0]         trip_count_d;

    logic [ACC_W-1:0]   acc_sum;
    logic               acc_carry;
    logic [10:0]        pwr_sum;

    assign trig_rise   = trigger & ~trig_prev;
    assign arm_last    = (cnt == CNT_W'(ARM_CYCLES - 1));
    assign ramp_last   = (cnt == CNT_W'(RAMP_CYCLES - 1));
    assign cool_last   = (cnt == CNT_W'(COOLDOWN_CYCLES - 1));
    assign fault_entry = FAULT_LATCH && (trip_count >= 4'(TRIP_LIMIT));

    // State and all outputs are registered together. The trigger history is
    // tracked in every state, so a trigger held high across a burst never
    // looks like a fresh edge once the FSM returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            acc         <= '0;
            trig_prev   <= 1'b0;
            ocd_start   <= 1'b0;
            ocd_enable  <= 1'b0;
            bridge_en   <= 1'b0;
            power_level <= '0;
            busy        <= 1'b0;
            last_peak   <= '0;
            peak_valid  <= 1'b0;
            ocd_trip    <= 1'b0;
            trip_count  <= '0;
            locked      <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= cnt_d;
            acc         <= acc_d;
            trig_prev   <= trigger;
            ocd_start   <= ocd_start_d;
            ocd_enable  <= ocd_enable_d;
            bridge_en   <= bridge_en_d;
            power_level <= power_level_d;
            busy        <= busy_d;
            last_peak   <= last_peak_d;
            peak_valid  <= peak_valid_d;
            ocd_trip    <= ocd_trip_d;
            trip_count  <= trip_count_d;
            locked      <= locked_d;
        end
    end

    // Next-state logic. In ARM and RAMP the priority is:
    // OCD halt, then abort, then ramp completion.
    // Halt and abort both lead to COOLDOWN; they differ only in bookkeeping.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (trig_rise) next_state = S_ARM;
            S_ARM: begin
                if (ocd_halt || abort) next_state = S_COOLDOWN;
                else if (arm_last)     next_state = S_RAMP;
            end
            S_RAMP:     if (ocd_halt || abort || ramp_last) next_state = S_COOLDOWN;
            S_COOLDOWN: if (cool_last) next_state = fault_entry ? S_FAULT : S_IDLE;
            S_FAULT:    if (fault_clr) next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Output logic. This computes the value every register takes at the next
    // edge, keyed on the transition being made, so each output changes in
    // the same cycle as the state it belongs to.
    always_comb begin
        acc_sum   = acc + ACC_W'(STEP_R);
        acc_carry = (acc_sum >= ACC_W'(RAMP_CYCLES));
        pwr_sum   = {1'b0, power_level} + 11'(STEP_Q) + {10'd0, acc_carry};

        ocd_start_d   = 1'b0;
        ocd_enable_d  = (next_state == S_ARM) || (next_state == S_RAMP);
        bridge_en_d   = (next_state == S_RAMP);
        busy_d        = (next_state != S_IDLE);
        locked_d      = FAULT_LATCH && (next_state == S_FAULT);
        power_level_d = '0;
        acc_d         = '0;
        last_peak_d   = last_peak;
        peak_valid_d  = 1'b0;
        ocd_trip_d    = ocd_trip;
        trip_count_d  = trip_count;

        if ((next_state == state) &&
            (state == S_ARM || state == S_RAMP || state == S_COOLDOWN))
            cnt_d = cnt + CNT_W'(1);
        else
            cnt_d = '0;

        if (state == S_IDLE && next_state == S_ARM) begin
            ocd_start_d = 1'b1;
            ocd_trip_d  = 1'b0;
        end

        // ARM leaves power and the accumulator at zero, so the first RAMP
        // cycle already shows one step. The last RAMP cycle then lands
        // exactly on POWER_MAX.
        if (next_state == S_RAMP) begin
            acc_d         = acc_carry ? (acc_sum - ACC_W'(RAMP_CYCLES)) : acc_sum;
            power_level_d = (pwr_sum > 11'(POWER_MAX)) ? 10'(POWER_MAX) : pwr_sum[9:0];
        end

        if (next_state == S_COOLDOWN && state != S_COOLDOWN) begin
            last_peak_d  = ocd_current_max;
            peak_valid_d = 1'b1;
            if (ocd_halt) begin
                ocd_trip_d   = 1'b1;
                trip_count_d = (trip_count == 4'hF) ? 4'hF : trip_count + 4'd1;
            end else begin
                trip_count_d = '0;
            end
        end

        if (state == S_FAULT && next_state == S_IDLE)
            trip_count_d = '0;
    end

endmodule

// File: tb/tb_qcw_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_qcw_burst_ctrl
//
// Directed testbench for qcw_burst_ctrl with short ARM, RAMP and COOLDOWN
// times. Expected values are worked out by hand from the burst timing:
//   ARM    4 cycles
//   RAMP   8 cycles
//   power  floor(k*1023/8) on RAMP cycle k
//   COOLDOWN 10 cycles
// Compile with QCW_FAULT_LATCH_EN to exercise the lockout path.
// ---------------------------------------------------------------------------
module tb_qcw_burst_ctrl;

    localparam int ARM  = 4;
    localparam int RAMP = 8;
    localparam int PMAX = 1023;
    localparam int COOL = 10;
    localparam int TLIM = 3;

    logic       clk;
    logic       rst;
    logic       trigger;
    logic       abort;
    logic       fault_clr;
    logic       ocd_halt;
    logic [9:0] ocd_current_max;
    logic       ocd_start;
    logic       ocd_enable;
    logic       bridge_en;
    logic [9:0] power_level;
    logic       busy;
    logic [9:0] last_peak;
    logic       peak_valid;
    logic       ocd_trip;
    logic [3:0] trip_count;
    logic       locked;

    int checkCount = 0;
    int failCount  = 0;

    qcw_burst_ctrl #(
        .ARM_CYCLES      (ARM),
        .RAMP_CYCLES     (RAMP),
        .POWER_MAX       (PMAX),
        .COOLDOWN_CYCLES (COOL),
        .TRIP_LIMIT      (TLIM)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .trigger         (trigger),
        .abort           (abort),
        .fault_clr       (fault_clr),
        .ocd_halt        (ocd_halt),
        .ocd_current_max (ocd_current_max),
        .ocd_start       (ocd_start),
        .ocd_enable      (ocd_enable),
        .bridge_en       (bridge_en),
        .power_level     (power_level),
        .busy            (busy),
        .last_peak       (last_peak),
        .peak_valid      (peak_valid),
        .ocd_trip        (ocd_trip),
        .trip_count      (trip_count),
        .locked          (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic trg, input logic abt, input logic clr,
                                 input logic halt, input logic [9:0] cur);
        trigger         = trg;
        abort           = abt;
        fault_clr       = clr;
        ocd_halt        = halt;
        ocd_current_max = cur;
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Raise trigger and check the first ARM cycle; optionally drop trigger.
    task automatic startBurst(input logic holdTrigger);
        trigger = 1'b1;
        tick();
        checkOutput("start_ocd_start", ocd_start, 1);
        checkOutput("start_ocd_enable", ocd_enable, 1);
        checkOutput("start_busy", busy, 1);
        checkOutput("start_ocd_trip_clr", ocd_trip, 0);
        checkOutput("start_bridge", bridge_en, 0);
        if (!holdTrigger) trigger = 1'b0;
    endtask

    // Call on the COOLDOWN entry cycle; runs out the remaining cooldown.
    task automatic coolDown(input logic expectFault);
        tick();
        checkOutput("cool_peak_valid_drop", peak_valid, 0);
        repeat (COOL - 2) tick();
        checkOutput("cool_last_busy", busy, 1);
        tick();
        checkOutput("cool_end_busy", busy, expectFault);
        checkOutput("cool_end_locked", locked, expectFault);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 10'd0);
        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_bridge", bridge_en, 0);
        checkOutput("rst_power", power_level, 0);
        checkOutput("rst_last_peak", last_peak, 0);
        checkOutput("rst_trip_count", trip_count, 0);
        checkOutput("rst_locked", locked, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();

        // Clean burst with trigger held high throughout.
        ocd_current_max = 10'd700;
        startBurst(1'b1);
        for (int i = 1; i < ARM; i++) begin
            tick();
            checkOutput("arm_ocd_start", ocd_start, 0);
            checkOutput("arm_bridge", bridge_en, 0);
            checkOutput("arm_power", power_level, 0);
        end
        for (int k = 1; k <= RAMP; k++) begin
            tick();
            checkOutput("ramp_bridge", bridge_en, 1);
            checkOutput("ramp_power", power_level, (k * PMAX) / RAMP);
        end
        tick();
        checkOutput("clean_bridge_off", bridge_en, 0);
        checkOutput("clean_peak_valid", peak_valid, 1);
        checkOutput("clean_last_peak", last_peak, 700);
        checkOutput("clean_ocd_enable", ocd_enable, 0);
        checkOutput("clean_power_zero", power_level, 0);
        checkOutput("clean_ocd_trip", ocd_trip, 0);
        checkOutput("clean_trip_count", trip_count, 0);
        coolDown(1'b0);
        repeat (3) tick();
        checkOutput("held_trigger_no_retrigger", busy, 0);
        trigger = 1'b0;
        tick();

        // OCD halt on RAMP cycle 3.
        ocd_current_max = 10'd900;
        startBurst(1'b0);
        repeat (ARM - 1) tick();
        repeat (3) tick();
        checkOutput("halt_pre_bridge", bridge_en, 1);
        checkOutput("halt_pre_power", power_level, 383);
        ocd_halt = 1'b1;
        tick();
        ocd_halt = 1'b0;
        checkOutput("halt_bridge_off", bridge_en, 0);
        checkOutput("halt_ocd_trip", ocd_trip, 1);
        checkOutput("halt_trip_count", trip_count, 1);
        checkOutput("halt_last_peak", last_peak, 900);
        checkOutput("halt_peak_valid", peak_valid, 1);
        checkOutput("halt_ocd_enable", ocd_enable, 0);
        coolDown(1'b0);

        // Halt and abort together on the final RAMP cycle count as a trip.
        ocd_current_max = 10'd1000;
        startBurst(1'b0);
        repeat (ARM - 1) tick();
        repeat (RAMP) tick();
        checkOutput("final_power", power_level, PMAX);
        ocd_halt = 1'b1;
        abort    = 1'b1;
        tick();
        ocd_halt = 1'b0;
        abort    = 1'b0;
        checkOutput("both_trip_count", trip_count, 2);
        checkOutput("both_ocd_trip", ocd_trip, 1);
        checkOutput("both_bridge_off", bridge_en, 0);
        coolDown(1'b0);

        // Trigger edges during RAMP and COOLDOWN are dropped; abort clears trips.
        ocd_current_max = 10'd300;
        startBurst(1'b0);
        repeat (ARM - 1) tick();
        repeat (2) tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_trip_count", trip_count, 0);
        checkOutput("abort_ocd_trip", ocd_trip, 0);
        checkOutput("abort_peak_valid", peak_valid, 1);
        checkOutput("abort_last_peak", last_peak, 300);
        checkOutput("abort_bridge_off", bridge_en, 0);
        tick();
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
        repeat (COOL - 3) tick();
        checkOutput("drop_cool_busy", busy, 1);
        tick();
        checkOutput("drop_idle", busy, 0);
        repeat (3) tick();
        checkOutput("drop_no_second_burst", busy, 0);
        checkOutput("drop_no_ocd_start", ocd_start, 0);
        trigger = 1'b0;
        tick();

        // Three consecutive OCD trips, halting in the first ARM cycle.
        for (int n = 1; n <= TLIM; n++) begin
            startBurst(1'b0);
            ocd_halt = 1'b1;
            tick();
            ocd_halt = 1'b0;
            checkOutput("trip_seq_count", trip_count, n);
            checkOutput("trip_seq_bridge", bridge_en, 0);
            checkOutput("trip_seq_ocd_trip", ocd_trip, 1);
`ifdef QCW_FAULT_LATCH_EN
            coolDown(n == TLIM);
`else
            coolDown(1'b0);
`endif
        end
`ifdef QCW_FAULT_LATCH_EN
        trigger = 1'b1;
        tick();
        tick();
        checkOutput("fault_ignores_trigger", ocd_start, 0);
        checkOutput("fault_locked", locked, 1);
        checkOutput("fault_busy", busy, 1);
        trigger   = 1'b0;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        checkOutput("fault_clr_locked", locked, 0);
        checkOutput("fault_clr_busy", busy, 0);
        checkOutput("fault_clr_trip_count", trip_count, 0);
`else
        checkOutput("nolatch_locked", locked, 0);
        checkOutput("nolatch_busy", busy, 0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        checkOutput("nolatch_trip_count", trip_count, 3);
        checkOutput("nolatch_locked_after_clr", locked, 0);
`endif
        tick();

        // Reset in the middle of RAMP clears outputs without a clock edge.
        startBurst(1'b0);
        repeat (ARM - 1) tick();
        repeat (3) tick();
        checkOutput("rst_mid_pre_bridge", bridge_en, 1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_bridge", bridge_en, 0);
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_power", power_level, 0);
        checkOutput("rst_mid_ocd_enable", ocd_enable, 0);
        checkOutput("rst_mid_last_peak", last_peak, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkOutput("rst_mid_idle", busy, 0);
        checkOutput("rst_mid_no_peak", peak_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
